// File: rtl/fifo_tx_pkg.sv
// ============================================================================
// Module   : fifo_tx_pkg
// Brief    : Shared Tx-path constants (lane mux and Tx FIFO use the same width)
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_tx_pkg;
    localparam int TX_DATA_WIDTH        = 8;
    localparam int TX_FIFO_ADDR_WIDTH   = 3;
    localparam int TX_ALMOST_FULL_TH    = 6;
    localparam int TX_ALMOST_EMPTY_TH   = 2;
endpackage

`default_nettype wire

// File: rtl/fifo_tx_if.sv
// ============================================================================
// Module   : fifo_tx_if
// Brief    : Lane-source / arbiter facing bus of the Tx FIFO
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fifo_tx_if
    import fifo_tx_pkg::*;
#(
    parameter int DATA_WIDTH = TX_DATA_WIDTH
);
    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow_err;
    logic                  underflow_err;

    // Source/arbiter side drives requests and observes data and flags.
    modport master (
        output push, data_in, pop,
        input  data_out, valid_out, full, empty, almost_full, almost_empty,
               overflow_err, underflow_err
    );

    modport slave (
        input  push, data_in, pop,
        output data_out, valid_out, full, empty, almost_full, almost_empty,
               overflow_err, underflow_err
    );
endinterface

`default_nettype wire

// File: rtl/fifo_tx_mem.sv
// ============================================================================
// Module   : fifo_mem
// Brief    : Register-array storage with synchronous write and registered read
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_mem
    import fifo_tx_pkg::*;
#(
    parameter int DATA_WIDTH = TX_DATA_WIDTH,
    parameter int ADDR_WIDTH = TX_FIFO_ADDR_WIDTH
) (
    input  wire logic                  clk,
    input  wire logic                  reset_L,
    input  wire logic                  wr_en,
    input  wire logic [ADDR_WIDTH-1:0] wr_addr,
    input  wire logic [DATA_WIDTH-1:0] wr_data,
    input  wire logic                  rd_en,
    input  wire logic [ADDR_WIDTH-1:0] rd_addr,
    output logic      [DATA_WIDTH-1:0] rd_data
);
    localparam int C_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [C_DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Storage is deliberately left unreset; only the output register clears.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read-before-write on a shared address returns the old word, which is
    // what a full FIFO doing push+pop needs.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
endmodule

`default_nettype wire

// File: rtl/fifo_tx.sv
// ============================================================================
// Module   : fifo_tx
// Brief    : Per-lane 8-entry Tx FIFO with registered output and sticky errors
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_tx
    import fifo_tx_pkg::*;
#(
    parameter int DATA_WIDTH      = TX_DATA_WIDTH,
    parameter int ADDR_WIDTH      = TX_FIFO_ADDR_WIDTH,
    parameter int ALMOST_FULL_TH  = TX_ALMOST_FULL_TH,
    parameter int ALMOST_EMPTY_TH = TX_ALMOST_EMPTY_TH
) (
    input  wire logic  clk,
    input  wire logic  reset_L,
    fifo_tx_if.slave   bus
);
    localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] C_AF_TH = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0] C_AE_TH = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);
    localparam logic [ADDR_WIDTH:0] C_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic                  valid_q;
    logic                  ovf_q;
    logic                  udf_q;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop_acc;
    logic                  w_push_acc;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_full     = (count_q == C_DEPTH);
    assign w_empty    = (count_q == '0);
    assign w_pop_acc  = bus.pop && !w_empty;
    // A full FIFO still takes a push when the same cycle frees a slot.
    assign w_push_acc = bus.push && (!w_full || w_pop_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push_acc) begin
            wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        end
        if (w_pop_acc) begin
            rd_ptr_d = rd_ptr_q + C_PTR_ONE;
        end
        case ({w_push_acc, w_pop_acc})
            2'b10:   count_d = count_q + C_ONE;
            2'b01:   count_d = count_q - C_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= w_pop_acc;
            if (bus.push && !w_push_acc) begin
                ovf_q <= 1'b1;
            end
            if (bus.pop && w_empty) begin
                udf_q <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .reset_L (reset_L),
        .wr_en   (w_push_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.data_in),
        .rd_en   (w_pop_acc),
        .rd_addr (rd_ptr_q),
        .rd_data (w_rd_data)
    );

    assign bus.data_out      = w_rd_data;
    assign bus.valid_out     = valid_q;
    assign bus.full          = w_full;
    assign bus.empty         = w_empty;
    assign bus.almost_full   = (count_q >= C_AF_TH);
    assign bus.almost_empty  = (count_q <= C_AE_TH);
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = udf_q;
endmodule

`default_nettype wire

// File: tb/tb_fifo_tx.sv
// ============================================================================
// Module   : tb_fifo_tx
// Brief    : Directed self-checking bench for the Tx FIFO
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_tx;
    logic clk;
    logic reset_L;
    int   n_checks;
    int   n_fails;

    fifo_tx_if #(.DATA_WIDTH(8)) bus ();

    fifo_tx dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic [7:0] d, input logic q);
        bus.push    = p;
        bus.data_in = d;
        bus.pop     = q;
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0);
        reset_L = 1'b0;
        step();
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset_L  = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        #2;
        do_reset();

        check_eq("rst_empty",  32'(bus.empty),         32'd1);
        check_eq("rst_aempty", 32'(bus.almost_empty),  32'd1);
        check_eq("rst_full",   32'(bus.full),          32'd0);
        check_eq("rst_afull",  32'(bus.almost_full),   32'd0);
        check_eq("rst_valid",  32'(bus.valid_out),     32'd0);
        check_eq("rst_data",   32'(bus.data_out),      32'h00);
        check_eq("rst_errs",   {30'd0, bus.overflow_err, bus.underflow_err}, 32'd0);

        // Fill with 0x11..0x88.
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 8'(8'h11 * k), 1'b0);
            step();
            check_eq($sformatf("fill_afull_%0d", k), 32'(bus.almost_full), (k >= 6) ? 32'd1 : 32'd0);
            check_eq($sformatf("fill_full_%0d", k),  32'(bus.full),        (k == 8) ? 32'd1 : 32'd0);
            check_eq($sformatf("fill_aempty_%0d", k), 32'(bus.almost_empty), (k <= 2) ? 32'd1 : 32'd0);
        end
        drive(1'b1, 8'h99, 1'b0);
        step();
        check_eq("ovf_set",  32'(bus.overflow_err), 32'd1);
        check_eq("ovf_full", 32'(bus.full),         32'd1);

        // Drain: 0x11..0x88 back to back; 0x99 must not appear.
        drive(1'b0, 8'h00, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step();
            check_eq($sformatf("drain_data_%0d", k),  32'(bus.data_out),  32'(8'h11 * k));
            check_eq($sformatf("drain_valid_%0d", k), 32'(bus.valid_out), 32'd1);
            if (k == 8) drive(1'b0, 8'h00, 1'b0);
        end
        check_eq("drain_empty", 32'(bus.empty), 32'd1);
        step();
        check_eq("drain_valid_end", 32'(bus.valid_out),     32'd0);
        check_eq("drain_hold",      32'(bus.data_out),      32'h88);
        check_eq("drain_no_udf",    32'(bus.underflow_err), 32'd0);

        // Pop on empty right after reset.
        do_reset();
        drive(1'b0, 8'h00, 1'b1);
        step();
        check_eq("udf_valid", 32'(bus.valid_out),     32'd0);
        check_eq("udf_data",  32'(bus.data_out),      32'h00);
        check_eq("udf_set",   32'(bus.underflow_err), 32'd1);

        // Push+pop on empty: push taken, no fall-through.
        drive(1'b1, 8'h5A, 1'b1);
        step();
        check_eq("pe_valid", 32'(bus.valid_out), 32'd0);
        check_eq("pe_empty", 32'(bus.empty),     32'd0);
        drive(1'b0, 8'h00, 1'b1);
        step();
        check_eq("pe_data",   32'(bus.data_out),      32'h5A);
        check_eq("pe_dvalid", 32'(bus.valid_out),     32'd1);
        check_eq("pe_empty2", 32'(bus.empty),         32'd1);
        check_eq("udf_stick", 32'(bus.underflow_err), 32'd1);

        // Push+pop on full: count stays 8, no overflow, 0xAA comes out last.
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 8'(k), 1'b0);
            step();
        end
        drive(1'b1, 8'hAA, 1'b1);
        step();
        check_eq("pf_data",  32'(bus.data_out),     32'h01);
        check_eq("pf_full",  32'(bus.full),         32'd1);
        check_eq("pf_noovf", 32'(bus.overflow_err), 32'd0);
        drive(1'b0, 8'h00, 1'b1);
        for (int k = 2; k <= 9; k++) begin
            step();
            check_eq($sformatf("pf_drain_%0d", k), 32'(bus.data_out), (k == 9) ? 32'hAA : 32'(k));
        end
        drive(1'b0, 8'h00, 1'b0);
        step();
        check_eq("pf_empty", 32'(bus.empty), 32'd1);

        // Wrap-around at occupancy 3.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'(k), 1'b0);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(i + 3), 1'b1);
            step();
            check_eq($sformatf("wrap_data_%0d", i),   32'(bus.data_out),     32'(i));
            check_eq($sformatf("wrap_occ_%0d", i),    {30'd0, bus.almost_empty, bus.almost_full}, 32'd0);
        end
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 20; i < 23; i++) begin
            step();
            check_eq($sformatf("wrap_tail_%0d", i), 32'(bus.data_out), 32'(i));
        end
        drive(1'b0, 8'h00, 1'b0);
        step();
        check_eq("wrap_empty", 32'(bus.empty), 32'd1);

        // Async reset mid-cycle with count=5 and valid_out=1.
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 8'(8'hB0 + k), 1'b0);
            step();
        end
        drive(1'b1, 8'hB6, 1'b1);
        step();
        check_eq("ar_pre_valid", 32'(bus.valid_out), 32'd1);
        check_eq("ar_pre_data",  32'(bus.data_out),  32'hB1);
        drive(1'b0, 8'h00, 1'b0);
        #2;
        reset_L = 1'b0;
        #1;
        check_eq("ar_valid",  32'(bus.valid_out),    32'd0);
        check_eq("ar_data",   32'(bus.data_out),     32'h00);
        check_eq("ar_empty",  32'(bus.empty),        32'd1);
        check_eq("ar_aempty", 32'(bus.almost_empty), 32'd1);
        check_eq("ar_full",   {30'd0, bus.full, bus.almost_full}, 32'd0);
        @(negedge clk);
        reset_L = 1'b1;
        drive(1'b1, 8'hC3, 1'b0);
        step();
        check_eq("ar_push", 32'(bus.empty), 32'd0);
        drive(1'b0, 8'h00, 1'b1);
        step();
        check_eq("ar_pop_data",  32'(bus.data_out),  32'hC3);
        check_eq("ar_pop_valid", 32'(bus.valid_out), 32'd1);
        drive(1'b0, 8'h00, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/fifo_tx.md
# fifo_tx

Eight-entry, 8-bit synchronous FIFO for the Tx path, one per lane, sitting directly upstream of the 8-bit 2:1 lane mux. It buffers words from the lane source and delivers each popped word as a registered `data_out` with a `valid_out` qualifier. These two outputs drive one input pair (`in0`/`valid_bit0` or `in1`/`valid_bit1`) of the mux. Occupancy flags feed the Tx arbiter that generates the mux `selector` and the pop strobes.

## Interface
- `DATA_WIDTH`, 8, word width; must match mux input width
- `ADDR_WIDTH`, 3, depth = 2**ADDR_WIDTH = 8 entries
- `ALMOST_FULL_TH`, 6, `almost_full` asserted when count >= this value
- `ALMOST_EMPTY_TH`, 2, `almost_empty` asserted when count <= this value
- `clk`  in  1  single clock; all state on rising edge
- `reset_L`  in  1  reset, asynchronous, active-low
- `push`  in  1  write request
- `data_in`  in  DATA_WIDTH  write data, sampled with `push`
- `pop`  in  1  read request
- `data_out`  out  DATA_WIDTH  registered read data
- `valid_out`  out  1  `data_out` holds a freshly popped word this cycle
- `full`, `empty`  out  1 each  count == 8 / count == 0
- `almost_full`, `almost_empty`  out  1 each  threshold flags
- `overflow_err`, `underflow_err`  out  1 each  sticky error flags

## Operation
- State:
  - write pointer `wr_ptr` and read pointer `rd_ptr`, ADDR_WIDTH bits each, wrap modulo 8
  - `count`, ADDR_WIDTH+1 bits, range 0..8
- Push accepted: `push && (!full || pop_accepted)`.
  - Writes `data_in` at `wr_ptr`; `wr_ptr` increments.
- Pop accepted: `pop && !empty`.
  - Next cycle: `data_out` = entry at `rd_ptr`, `valid_out` = 1; `rd_ptr` increments.
- Pop not accepted: `valid_out` = 0 next cycle; `data_out` holds its last value.
- `count` update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Push and pop together while full: both accepted; `count` stays 8; no overflow.
- Push and pop together while empty:
  - pop rejected, `underflow_err` set
  - push accepted; `count` becomes 1
  - no fall-through: the word becomes readable no earlier than the next cycle
- Push rejected (full and no accepted pop): data dropped, pointers unchanged, `overflow_err` set.
- `pop` while empty: `underflow_err` set.
- Error flags are sticky until reset.
- Flags `full`, `empty`, `almost_full`, `almost_empty` decode combinationally from the registered `count`.
- Reset asserted at any time, including mid-burst, forces:
  - pointers and `count` = 0
  - `data_out` = 0, `valid_out` = 0
  - `empty` = 1, `almost_empty` = 1
  - `full` = 0, `almost_full` = 0
  - both error flags = 0
- Storage array is not cleared on reset; stale contents are unreachable.

## Timing
- Pop-to-data latency: 1 cycle. `pop` sampled at edge N gives `data_out`/`valid_out` valid after edge N, for exactly one cycle per accepted pop.
- Back-to-back pops give one word per cycle with `valid_out` held high.
- Push-to-visibility: word written at edge N affects `count`/flags after edge N and is poppable at edge N+1.
- Flags change only after a clock edge, or asynchronously on reset assertion.
- Reset release is synchronous in effect: the first push/pop is honoured at the first rising edge after `reset_L` goes high.

## Structure
- Shared include with default constants: `TX_DATA_WIDTH` = 8, `TX_FIFO_ADDR_WIDTH` = 3, thresholds. The lane mux and this FIFO use the same width constant.
- One sub-module, `fifo_mem`: 2**ADDR_WIDTH × DATA_WIDTH register array.
  - synchronous write port: `wr_en`, `wr_addr`, `wr_data`
  - registered read port: `rd_en`, `rd_addr`, `rd_data`
  - no reset on storage
- `fifo_tx` holds pointers, count, flags, errors and `valid_out`.

## Test plan
- Reset, then 8 pushes of 0x11..0x88 without pop:
  - `almost_full` rises after the 6th push, `full` after the 8th
  - a 9th push of 0x99 is dropped and sets `overflow_err`
- Drain case: 8 consecutive pops after the previous scenario
  - `data_out` = 0x11..0x88 on consecutive cycles, `valid_out` high for exactly 8 cycles
  - `empty` = 1 after the last pop, no `underflow_err`
- Pop when empty after reset:
  - `valid_out` stays 0, `data_out` stays 0x00
  - `underflow_err` = 1 and remains 1 through later valid traffic until reset
- Simultaneous push/pop:
  - with full FIFO, push 0xAA + pop: count stays 8, no overflow, 0xAA emerges 8 pops later
  - with empty FIFO, push 0x5A + pop: count = 1, underflow set; 0x5A emerges on the next pop
- Wrap-around: 20 interleaved push/pop cycles, occupancy held at 3.
  - Pointers pass index 7→0 several times.
  - Output order matches input order (e.g. 0x00..0x13 incrementing), with no loss or duplication.
- `reset_L` pulsed low mid-cycle with count = 5 and `valid_out` = 1:
  - all outputs go to reset values immediately, without waiting for `clk`
  - after release, push 0xC3 then pop yields 0xC3, not stale data
